// File: rtl/db_sao_band_stat_pkg.sv
// Shared SAO band-statistics definitions: band geometry, beat width,
// FSM encoding and the state-saturation limits used when
// SAO_BAND_STAT_SAT_EN is defined.
package db_sao_band_stat_pkg;

   localparam int NUM_BANDS    = 32;
   localparam int BAND_IDX_W   = 5;
   localparam int PIX_PER_BEAT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2
   } sao_state_e;

   // Largest value a signed state of the given width can hold.
   function automatic longint state_max(input int diff_width);
      return (longint'(1) <<< (diff_width - 1)) - 1;
   endfunction

   // Smallest value a signed state of the given width can hold.
   function automatic longint state_min(input int diff_width);
      return -(longint'(1) <<< (diff_width - 1));
   endfunction

endpackage

// File: rtl/db_sao_band_acc.sv
// One band's accumulator: matches the four pixels of a beat against this
// band, sums the masked diffs and counts the hits. The count saturates;
// the state wraps, or saturates when SAO_BAND_STAT_SAT_EN is defined.
module db_sao_band_acc
   import db_sao_band_stat_pkg::*;
#(
   parameter int BAND        = 0,
   parameter int PIXEL_WIDTH = 8,
   parameter int DIFF_WIDTH  = 20,
   parameter int NUM_WIDTH   = 13
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clr_i,
   input  logic                                  en_i,
   input  logic [PIX_PER_BEAT*BAND_IDX_W-1:0]    band_i,
   input  logic [PIX_PER_BEAT*(PIXEL_WIDTH+1)-1:0] diff_i,
   input  logic [PIX_PER_BEAT-1:0]               mask_i,
   output logic signed [DIFF_WIDTH-1:0]          state_o,
   output logic [NUM_WIDTH-1:0]                  num_o
);

   localparam int DW     = PIXEL_WIDTH + 1;
   localparam int BSUM_W = DW + 2;
   localparam int NSUM_W = NUM_WIDTH + 1;
   localparam logic [BAND_IDX_W-1:0] MY_BAND = BAND_IDX_W'(BAND);

   logic signed [BSUM_W-1:0]     beat_sum;
   logic [2:0]                   beat_cnt;
   logic [NSUM_W-1:0]            num_sum;
   logic signed [DIFF_WIDTH-1:0] state_d, state_q;
   logic [NUM_WIDTH-1:0]         num_d, num_q;

   // Sum the diffs and count the pixels of this beat that fall in this band.
   // NOTE: every variable gets a default before any condition, so no latch is inferred.
   always_comb begin
      beat_sum = '0;
      beat_cnt = '0;
      for (int k = 0; k < PIX_PER_BEAT; k++) begin
         if (mask_i[k] && (band_i[k*BAND_IDX_W +: BAND_IDX_W] == MY_BAND)) begin
            beat_sum = beat_sum + BSUM_W'($signed(diff_i[k*DW +: DW]));
            beat_cnt = beat_cnt + 3'd1;
         end
      end
   end

`ifdef SAO_BAND_STAT_SAT_EN
   localparam int SUM_W = DIFF_WIDTH + 1;
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(state_max(DIFF_WIDTH));
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(state_min(DIFF_WIDTH));
   logic signed [SUM_W-1:0] state_sum;

   // Saturating state update: clamp the one-bit-wider sum to the state range.
   always_comb begin
      state_sum = SUM_W'(state_q) + SUM_W'(beat_sum);
      state_d   = state_sum[DIFF_WIDTH-1:0];
      if (state_sum > SAT_MAX) begin
         state_d = SAT_MAX[DIFF_WIDTH-1:0];
      end else if (state_sum < SAT_MIN) begin
         state_d = SAT_MIN[DIFF_WIDTH-1:0];
      end
   end
`else
   // Wrapping state update in two's complement.
   always_comb begin
      state_d = state_q + DIFF_WIDTH'(beat_sum);
   end
`endif

   // Count update, pinned at all-ones once it would overflow.
   always_comb begin
      num_sum = {1'b0, num_q} + NSUM_W'(beat_cnt);
      num_d   = num_sum[NSUM_W-1] ? '1 : num_sum[NUM_WIDTH-1:0];
   end

   // Accumulator registers; clear wins over an update in the same cycle.
   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: these accumulators are flops rather than a RAM, so they take the async reset directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         num_q   <= '0;
      end else if (clr_i) begin
         state_q <= '0;
         num_q   <= '0;
      end else if (en_i) begin
         state_q <= state_d;
         num_q   <= num_d;
      end
   end

   assign state_o = state_q;
   assign num_o   = num_q;

endmodule

// File: rtl/db_sao_band_stat.sv
// SAO band-offset statistics collector. Stage 1 registers band index and
// diff per pixel, stage 2 updates the 32 per-band accumulators, then the
// records are drained in band order, one per cycle, followed by done_o.
// Optional feature macro: SAO_BAND_STAT_SAT_EN (saturating state sums).
module db_sao_band_stat
   import db_sao_band_stat_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int DIFF_WIDTH  = 20,
   parameter int NUM_WIDTH   = 13
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start_i,
   input  logic                                valid_i,
   input  logic                                last_i,
   input  logic [PIX_PER_BEAT*PIXEL_WIDTH-1:0] org_i,
   input  logic [PIX_PER_BEAT*PIXEL_WIDTH-1:0] rec_i,
   input  logic [PIX_PER_BEAT-1:0]             mask_i,
   output logic signed [DIFF_WIDTH-1:0]        b_state_o,
   output logic [NUM_WIDTH-1:0]                b_num_o,
   output logic [BAND_IDX_W-1:0]               b_idx_o,
   output logic                                data_valid_o,
   output logic                                done_o,
   output logic                                busy_o
);

   localparam int DW = PIXEL_WIDTH + 1;
   localparam logic [BAND_IDX_W-1:0] LAST_BAND = BAND_IDX_W'(NUM_BANDS - 1);

   sao_state_e                        state_d, state_q;
   logic [BAND_IDX_W-1:0]             cnt_d, cnt_q;
   logic                              accept;
   logic [PIX_PER_BEAT*BAND_IDX_W-1:0] s1_band_d, s1_band_q;
   logic [PIX_PER_BEAT*DW-1:0]        s1_diff_d, s1_diff_q;
   logic [PIX_PER_BEAT-1:0]           s1_mask_q;
   logic                              s1_valid_q, s1_last_q, s2_last_q;
   logic                              last_rec_q;
   logic signed [DIFF_WIDTH-1:0]      band_state [NUM_BANDS];
   logic [NUM_WIDTH-1:0]              band_num   [NUM_BANDS];

   // Beats are taken only in ACC, never alongside start_i, and not once the
   // CTB's last beat is already in flight through the pipeline.
   assign accept = (state_q == ST_ACC) && valid_i && !start_i && !s1_last_q && !s2_last_q;

   // Per-pixel band index (top five bits of rec) and signed org - rec.
   always_comb begin
      s1_band_d = '0;
      s1_diff_d = '0;
      for (int k = 0; k < PIX_PER_BEAT; k++) begin
         s1_band_d[k*BAND_IDX_W +: BAND_IDX_W] = rec_i[k*PIXEL_WIDTH + PIXEL_WIDTH - 1 -: BAND_IDX_W];
         s1_diff_d[k*DW +: DW] = {1'b0, org_i[k*PIXEL_WIDTH +: PIXEL_WIDTH]}
                                - {1'b0, rec_i[k*PIXEL_WIDTH +: PIXEL_WIDTH]};
      end
   end

   // Pipeline registers for stage 1 and the stage-2 last flag; start_i flushes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_mask_q  <= '0;
         s1_band_q  <= '0;
         s1_diff_q  <= '0;
         s2_last_q  <= 1'b0;
      end else if (start_i) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_mask_q  <= '0;
         s1_band_q  <= '0;
         s1_diff_q  <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_last_q  <= accept && last_i;
         s1_mask_q  <= accept ? mask_i : '0;
         s1_band_q  <= s1_band_d;
         s1_diff_q  <= s1_diff_d;
         s2_last_q  <= s1_valid_q && s1_last_q;
      end
   end

   for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      db_sao_band_acc #(
         .BAND        (b),
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .DIFF_WIDTH  (DIFF_WIDTH),
         .NUM_WIDTH   (NUM_WIDTH)
      ) u_acc (
         .clk     (clk),
         .rst     (rst),
         .clr_i   (start_i),
         .en_i    (s1_valid_q),
         .band_i  (s1_band_q),
         .diff_i  (s1_diff_q),
         .mask_i  (s1_mask_q),
         .state_o (band_state[b]),
         .num_o   (band_num[b])
      );
   end

   // FSM next state and drain counter; start_i overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (start_i) begin
         state_d = ST_ACC;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (s2_last_q) begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end
            end
            ST_DRAIN: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BAND) begin
                  state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM state and drain counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered record outputs and the done pulse one cycle after record 31.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_state_o    <= '0;
         b_num_o      <= '0;
         b_idx_o      <= '0;
         data_valid_o <= 1'b0;
         last_rec_q   <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         data_valid_o <= (state_q == ST_DRAIN) && !start_i;
         last_rec_q   <= (state_q == ST_DRAIN) && (cnt_q == LAST_BAND) && !start_i;
         done_o       <= last_rec_q;
         if (state_q == ST_DRAIN) begin
            b_state_o <= band_state[cnt_q];
            b_num_o   <= band_num[cnt_q];
            b_idx_o   <= cnt_q;
         end
      end
   end

   assign busy_o = (state_q != ST_IDLE);

endmodule
